hub75_capture: RTL
==================

# hub75_capture

Receive-side HUB75 monitor: samples the panel-side HUB75 bus (data clock, latch, output-enable, row address, two RGB lanes), rebuilds each shifted row into a parallel record, and hands it out over a valid/ready interface. It sits at the far end of the HUB75 link from our panel driver. It serves as a loopback checker on hardware and as a golden receiver in benches. It also measures output-enable on-time per latched row.

## Interface
- NUM_COLS, 64, pixels shifted per row (one per hub75_clk rising edge)
- SCAN_RATE, 32, row addresses; address width is $clog2(SCAN_RATE)
- SYNC_STAGES, 2, flip-flop depth of input synchronizers (≥2)
- OE_CNT_W, 16, width of the OE on-time counter
- clk_in  input  1  system clock; all logic on rising edge
- rst_in_n  input  1  asynchronous, active-low reset
- hub75_clk  input  1  panel shift clock; asynchronous to clk_in
- hub75_latch  input  1  row latch; rising edge ends a row
- hub75_OE  input  1  output enable, active low
- hub75_addr  input  $clog2(SCAN_RATE)  row address
- hub75_rgb0, hub75_rgb1  input  3 each  upper/lower half pixel data
- row_valid  output  1  record available
- row_ready  input  1  consumer accepts record when high with row_valid
- row_addr  output  $clog2(SCAN_RATE)  address sampled at latch edge
- row_rgb0, row_rgb1  output  3*NUM_COLS each  column c at bits [3c+:3]
- row_count  output  $clog2(NUM_COLS)+1  shift edges seen for this row, saturating
- row_count_err  output  1  row_count != NUM_COLS
- oe_cycles  output  OE_CNT_W  clk_in cycles with OE low between previous and current latch, saturating
- overflow  output  1  sticky: a record was dropped

## Operation
- All seven bus inputs pass through identical SYNC_STAGES synchronizers, so data, address and strobes stay cycle-aligned; one further register stage provides edge detection.
- Shift edge (synced hub75_clk 0→1): shift register moves one pixel toward column 0. The new rgb0/rgb1 enter column NUM_COLS-1, so the first pixel shifted ends at column 0 after exactly NUM_COLS shifts. Increment shift counter, saturating at 2^width-1.
- OE counter: increments every cycle synced hub75_OE==0, saturating at all-ones.
- Latch edge (synced hub75_latch 0→1): snapshot shift register, shift count, synced address and OE counter into the output holding registers. Then clear the shift counter and OE counter; the shift register is not cleared. A shift edge and a latch edge in the same cycle: the shift is applied first and included in the snapshot.
- Output FSM, two states:
  - EMPTY: row_valid=0. On latch edge, load and go to FULL.
  - FULL: row_valid=1, outputs held stable. row_ready=1 with no latch edge goes to EMPTY.
  - FULL, latch edge with row_ready=1 in the same cycle: the old record is consumed, the new one is loaded, and the state stays FULL.
  - FULL, latch edge with row_ready=0: the new record is dropped, overflow is set, and the held record is unchanged.
- overflow clears only on reset.

## Timing
- Reset (async assert, sync release internal): row_valid=0, row_addr=0, row_rgb0/1=0, row_count=0, row_count_err=0, oe_cycles=0, overflow=0. Synchronizers, counters and shift register also clear, and the FSM enters EMPTY.
- Reset mid-row discards the partial row; the next row count starts from 0.
- Latency: an input edge first sampled at clk_in edge k is detected at k+SYNC_STAGES. row_valid rises after edge k+SYNC_STAGES (k+2 at default).
- Input requirement: hub75_clk high and low phases each ≥ SYNC_STAGES+1 clk_in periods. rgb/addr must be stable ≥ SYNC_STAGES+1 periods around each hub75_clk/latch rise. Violations produce undefined data but no lockup.
- Throughput: one record per latch. The consumer has until the next latch edge to accept.

## Test plan
- 64 hub75_clk pulses, pixel k carries rgb0=k%8, rgb1=7-k%8, then latch with addr=5 -> row_valid 2 cycles after latch sampled. row_addr=5, row_count=64, row_count_err=0, column c holds rgb0=c%8.
- Short row: 10 shifts then latch -> row_count=10, row_count_err=1. The next 64-shift row reports row_count=64, row_count_err=0.
- OE held low 100 clk_in cycles between latches -> oe_cycles=100. OE low >65535 cycles -> oe_cycles=16'hFFFF.
- row_ready=0 across two latches -> first record held unchanged, overflow=1 permanently. Repeat with row_ready=1 exactly on the second latch-edge cycle -> second record loaded, row_valid stays 1, overflow=0.
- Shift edge coincident with latch edge on pixel 64 -> row_count=64, and that pixel appears at column NUM_COLS-1.
- rst_in_n pulsed low after 30 shifts with row_valid=1 -> all outputs 0 immediately. A following full row reports row_count=64.

Source files
------------

// File: rtl/hub75_capture.sv
// hub75_capture: samples a HUB75 bus, rebuilds each latched row and presents it over valid/ready.
module hub75_capture #(
  parameter int NUM_COLS = 64,
  parameter int SCAN_RATE = 32,
  parameter int SYNC_STAGES = 2,
  parameter int OE_CNT_W = 16
) (
  input  logic                          clk_in,
  input  logic                          rst_in_n,
  input  logic                          hub75_clk,
  input  logic                          hub75_latch,
  input  logic                          hub75_OE,
  input  logic [$clog2(SCAN_RATE)-1:0]  hub75_addr,
  input  logic [2:0]                    hub75_rgb0,
  input  logic [2:0]                    hub75_rgb1,
  output logic                          row_valid,
  input  logic                          row_ready,
  output logic [$clog2(SCAN_RATE)-1:0]  row_addr,
  output logic [3*NUM_COLS-1:0]         row_rgb0,
  output logic [3*NUM_COLS-1:0]         row_rgb1,
  output logic [$clog2(NUM_COLS):0]     row_count,
  output logic                          row_count_err,
  output logic [OE_CNT_W-1:0]           oe_cycles,
  output logic                          overflow
);
  localparam int AW = $clog2(SCAN_RATE);
  localparam int CW = $clog2(NUM_COLS) + 1;
  localparam int BW = AW + 9;
  localparam int PW = 3 * NUM_COLS;
  typedef enum logic {EMPTY, FULL} state_t;
  logic [1:0] rst_sync;
  logic rst_n;
  logic [BW-1:0] sync [SYNC_STAGES];
  logic [BW-1:0] cur;
  logic prev_clk, prev_lat;
  logic s_clk, s_lat, s_oe, shift_edge, latch_edge, load;
  logic [AW-1:0] s_addr;
  logic [2:0] s_rgb0, s_rgb1;
  logic [PW-1:0] sr0, sr1, sr0_next, sr1_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [OE_CNT_W-1:0] oe_cnt;
  state_t state;
  // Reset asserts immediately but releases two clocks later, clean against clk_in.
  always_ff @(posedge clk_in or negedge rst_in_n)
    if (!rst_in_n) rst_sync <= '0;
    else rst_sync <= {rst_sync[0], 1'b1};
  assign rst_n = rst_sync[1];
  assign cur = sync[SYNC_STAGES-1];
  assign {s_clk, s_lat, s_oe, s_addr, s_rgb0, s_rgb1} = cur;
  assign shift_edge = s_clk & ~prev_clk;
  assign latch_edge = s_lat & ~prev_lat;
  assign sr0_next = shift_edge ? {s_rgb0, sr0[PW-1:3]} : sr0;
  assign sr1_next = shift_edge ? {s_rgb1, sr1[PW-1:3]} : sr1;
  assign cnt_next = (shift_edge && cnt != '1) ? cnt + 1'b1 : cnt;
  assign load = latch_edge && (state == EMPTY || row_ready);
  assign row_valid = state == FULL;
  // Whole bus goes through one synchronizer chain so data and strobes stay aligned.
  always_ff @(posedge clk_in or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync[i] <= '0;
      prev_clk <= 1'b0;
      prev_lat <= 1'b0;
    end else begin
      sync[0] <= {hub75_clk, hub75_latch, hub75_OE, hub75_addr, hub75_rgb0, hub75_rgb1};
      for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
      prev_clk <= s_clk;
      prev_lat <= s_lat;
    end
  // Pixel shift register plus per-row shift and OE-low counters, cleared by each latch.
  always_ff @(posedge clk_in or negedge rst_n)
    if (!rst_n) begin
      sr0 <= '0;
      sr1 <= '0;
      cnt <= '0;
      oe_cnt <= '0;
    end else begin
      sr0 <= sr0_next;
      sr1 <= sr1_next;
      cnt <= latch_edge ? '0 : cnt_next;
      oe_cnt <= latch_edge ? '0 : (!s_oe && oe_cnt != '1) ? oe_cnt + 1'b1 : oe_cnt;
    end
  // One-deep output holding register; a latch while full and unaccepted is dropped.
  always_ff @(posedge clk_in or negedge rst_n)
    if (!rst_n) begin
      state <= EMPTY;
      row_addr <= '0;
      row_rgb0 <= '0;
      row_rgb1 <= '0;
      row_count <= '0;
      row_count_err <= 1'b0;
      oe_cycles <= '0;
      overflow <= 1'b0;
    end else begin
      if (load) begin
        row_addr <= s_addr;
        row_rgb0 <= sr0_next;
        row_rgb1 <= sr1_next;
        row_count <= cnt_next;
        row_count_err <= cnt_next != CW'(NUM_COLS);
        oe_cycles <= oe_cnt;
      end
      if (latch_edge && state == FULL && !row_ready) overflow <= 1'b1;
      state <= load ? FULL : row_ready ? EMPTY : state;
    end
endmodule
